req_ack_responder: RTL and testbench
====================================

# req_ack_responder

Receiving end of the transmitter/receiver request–acknowledge handshake. Every cycle in which the transmitter's request is sampled high, the block schedules a one-cycle acknowledge exactly D clock edges later, with D programmable and always inside the [MIN_DLY:MAX_DLY] window. The window is the same one our concurrent assertions check (`req |-> ##[2:5] ack`). The block sits on the receive side of the link and also provides request/acknowledge counters and a sticky configuration error flag for status readout.

## Interface
- MIN_DLY, 2, minimum request-to-ack distance in clock edges (≥1)
- MAX_DLY, 5, maximum request-to-ack distance in clock edges (≥MIN_DLY, ≤15)
- CNT_W, 16, width of status counters

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tx_req  in  1  request from transmitter, sampled at posedge clk
- en  in  1  responder enable; new requests accepted only when 1
- cfg_dly  in  4  requested delay D; clamped into window
- rx_ack  out  1  registered acknowledge, one cycle per scheduled slot
- busy  out  1  1 while any acknowledge is scheduled and not yet issued
- clamp_err  out  1  sticky; set when an accepted request saw cfg_dly outside window
- req_cnt  out  CNT_W  accepted request count, saturating
- ack_cnt  out  CNT_W  rx_ack-high cycle count, saturating

## Operation
- Acceptance: at an edge T with tx_req=1 and en=1, one request is accepted. D is computed as cfg_dly clamped into [MIN_DLY, MAX_DLY], using the cfg_dly value sampled at T.
- Scheduling: an accepted request at edge T guarantees rx_ack=1 as sampled at edge T+D. A schedule register of MAX_DLY slots holds pending acknowledges and shifts one slot per edge.
- Merging: requests whose target edges coincide produce a single rx_ack cycle. rx_ack is 1 only in cycles targeted by at least one request; otherwise it is 0. There is no overflow condition, because each slot is a single bit.
- tx_req held high for N consecutive accepted edges with constant D gives rx_ack high for N consecutive edges, starting D edges after the first.
- en=0: tx_req is ignored and not counted. Already-scheduled acknowledges are still issued. en changes take effect at the edge they are sampled.
- clamp_err: set at an accepting edge when cfg_dly<MIN_DLY or cfg_dly>MAX_DLY. It stays set until rst.
- busy: 1 when any schedule slot is set, including a slot set at the current edge. It is 0 otherwise.
- req_cnt: increments by 1 per accepting edge.
- ack_cnt: increments by 1 per edge at which rx_ack is sampled 1.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- No FSM beyond the schedule register. All state is in the schedule, the counters and clamp_err.

## Timing
- Reset values: rx_ack=0, busy=0, clamp_err=0, req_cnt=0, ack_cnt=0, schedule cleared.
- Reset is applied asynchronously (outputs clear immediately) and released synchronously to clk by the integrator.
- Reset mid-operation: all pending acknowledges are discarded. No rx_ack pulse follows reset deassertion unless a new request is accepted.
- Latency: exactly D edges from the accepting edge to the edge where rx_ack is sampled 1. rx_ack changes only just after posedge clk.
- The first edge after reset release can accept a request.
- cfg_dly changing between requests is legal. Each request uses its own sampled D, so acknowledges may interleave or merge.
- No combinational path from any input to rx_ack or busy. Counters and clamp_err are registered.

## Test plan
- Single request, cfg_dly=3: tx_req high at edge 10 only -> rx_ack sampled 1 at edge 13 only; req_cnt=1, ack_cnt=1; busy high from edge 10 until rx_ack is sampled at 13.
- Held request, cfg_dly=2: tx_req high at edges 1–6 -> rx_ack high at edges 3–8; req_cnt=6, ack_cnt=6; the assertion `tx_req |-> ##[2:5] rx_ack` passes on every attempt.
- Clamping: cfg_dly=0 with a request at edge 5 -> ack at edge 7, clamp_err=1. cfg_dly=9 with a request at edge 20 -> ack at edge 25. clamp_err stays 1.
- Merge: request at edge 0 with D=5 and request at edge 2 with D=3 -> single rx_ack cycle at edge 5; req_cnt=2, ack_cnt=1.
- Enable and reset: requests with en=0 are not counted and produce no ack. A request at edge 0 with D=4, followed by rst asserted between edges 2 and 3, gives no rx_ack at edge 4 and all outputs 0 immediately.
- Saturation (CNT_W=4): 20 held requests -> req_cnt=15 and ack_cnt=15, with no wrap.

Source files
------------

// File: rtl/req_ack_responder.sv
// Receive-side responder for a request/acknowledge handshake: every accepted request
// schedules a one-cycle rx_ack D edges later, with D clamped into [MIN_DLY:MAX_DLY].
module req_ack_responder #(
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_req,
  input  logic             en,
  input  logic [3:0]       cfg_dly,
  output logic             rx_ack,
  output logic             busy,
  output logic             clamp_err,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] ack_cnt
);

  localparam logic [3:0]       MIN_D   = 4'(MIN_DLY);
  localparam logic [3:0]       MAX_D   = 4'(MAX_DLY);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_DLY-1:0] r_sched;
  logic [MAX_DLY-1:0] w_sched_nxt;
  logic               r_busy;
  logic               r_clamp_err;
  logic [CNT_W-1:0]   r_req_cnt;
  logic [CNT_W-1:0]   r_ack_cnt;
  logic               w_accept;
  logic               w_out_of_win;
  logic [3:0]         w_dly;

  // Request acceptance and delay clamping into the legal window
  always_comb begin
    w_accept     = tx_req & en;
    w_out_of_win = (cfg_dly < MIN_D) || (cfg_dly > MAX_D);
    if (cfg_dly < MIN_D) begin
      w_dly = MIN_D;
    end else if (cfg_dly > MAX_D) begin
      w_dly = MAX_D;
    end else begin
      w_dly = cfg_dly;
    end
  end

  // Slot k holds an ack due k+1 edges from now; coinciding targets merge into one bit
  always_comb begin
    w_sched_nxt = r_sched >> 1;
    for (int k = 0; k < MAX_DLY; k++) begin
      w_sched_nxt[k] = w_sched_nxt[k] | (w_accept && (w_dly == 4'(k + 1)));
    end
  end

  // Schedule, status flags and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sched     <= {MAX_DLY{1'b0}};
      r_busy      <= 1'b0;
      r_clamp_err <= 1'b0;
      r_req_cnt   <= {CNT_W{1'b0}};
      r_ack_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_sched <= w_sched_nxt;
      r_busy  <= |w_sched_nxt;
      if (w_accept && w_out_of_win) begin
        r_clamp_err <= 1'b1;
      end
      if (w_accept && (r_req_cnt != CNT_MAX)) begin
        r_req_cnt <= r_req_cnt + CNT_W'(1);
      end
      if (r_sched[0] && (r_ack_cnt != CNT_MAX)) begin
        r_ack_cnt <= r_ack_cnt + CNT_W'(1);
      end
    end
  end

  assign rx_ack    = r_sched[0];
  assign busy      = r_busy;
  assign clamp_err = r_clamp_err;
  assign req_cnt   = r_req_cnt;
  assign ack_cnt   = r_ack_cnt;

endmodule

// File: tb/tb_req_ack_responder.sv
// Self-checking bench for req_ack_responder: hand-written vector table, directed
// reset/saturation sequences and random traffic checked against a target-edge model.
module tb_req_ack_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_req = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  cfg_dly = 4'd0;
  logic        rx_ack, busy, clamp_err;
  logic [15:0] req_cnt, ack_cnt;
  logic        s_rx_ack, s_busy, s_clamp_err;
  logic [3:0]  s_req_cnt, s_ack_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int cur      = 0;

  bit exp_ack[int];
  int m_req   = 0;
  int m_ack   = 0;
  int m_clamp = 0;

  typedef struct {
    logic       req;
    logic       en;
    logic [3:0] cfg;
    logic       ack;
    logic       busy;
    logic       clamp;
  } vec_t;
  vec_t tab[45];

  req_ack_responder u_dut (
    .clk(clk), .rst(rst), .tx_req(tx_req), .en(en), .cfg_dly(cfg_dly),
    .rx_ack(rx_ack), .busy(busy), .clamp_err(clamp_err),
    .req_cnt(req_cnt), .ack_cnt(ack_cnt)
  );

  req_ack_responder #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .tx_req(tx_req), .en(en), .cfg_dly(cfg_dly),
    .rx_ack(s_rx_ack), .busy(s_busy), .clamp_err(s_clamp_err),
    .req_cnt(s_req_cnt), .ack_cnt(s_ack_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cur = cur + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, cur);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic int model_busy(input int e);
    int b = 0;
    foreach (exp_ack[k]) if (k >= e && exp_ack[k]) b = 1;
    return b;
  endfunction

  // Called at a negedge: checks what the upcoming edge will sample, then applies inputs.
  task automatic cycle(input logic req, input logic e, input logic [3:0] cfg);
    int edge_i;
    int d;
    int a;
    edge_i = cur;
    a = exp_ack.exists(edge_i) ? 1 : 0;
    chk("rx_ack", int'(rx_ack), a);
    chk("busy", int'(busy), model_busy(edge_i));
    chk("clamp_err", int'(clamp_err), m_clamp);
    chk("req_cnt", int'(req_cnt), sat(m_req, 65535));
    chk("ack_cnt", int'(ack_cnt), sat(m_ack, 65535));
    chk("sat_rx_ack", int'(s_rx_ack), a);
    chk("sat_busy", int'(s_busy), model_busy(edge_i));
    chk("sat_req_cnt", int'(s_req_cnt), sat(m_req, 15));
    chk("sat_ack_cnt", int'(s_ack_cnt), sat(m_ack, 15));
    tx_req  = req;
    en      = e;
    cfg_dly = cfg;
    if (a != 0) m_ack++;
    if (req && e) begin
      m_req++;
      d = int'(cfg);
      if (d < 2 || d > 5) m_clamp = 1;
      if (d < 2) d = 2;
      if (d > 5) d = 5;
      exp_ack[edge_i + d] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset (outputs must clear at once), clears the model, releases at a negedge.
  task automatic do_reset();
    rst    = 1'b1;
    tx_req = 1'b0;
    #1;
    chk("rst_rx_ack", int'(rx_ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clamp_err", int'(clamp_err), 0);
    chk("rst_req_cnt", int'(req_cnt), 0);
    chk("rst_ack_cnt", int'(ack_cnt), 0);
    exp_ack.delete();
    m_req   = 0;
    m_ack   = 0;
    m_clamp = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_v(input int i, input logic r, input logic e, input logic [3:0] c,
                       input logic a, input logic b);
    tab[i].req  = r;
    tab[i].en   = e;
    tab[i].cfg  = c;
    tab[i].ack  = a;
    tab[i].busy = b;
  endtask

  initial begin
    for (int i = 0; i < 45; i++) begin
      tab[i].req   = 1'b0;
      tab[i].en    = 1'b1;
      tab[i].cfg   = 4'd0;
      tab[i].ack   = 1'b0;
      tab[i].busy  = 1'b0;
      tab[i].clamp = (i >= 25);
    end
    // single request, D=3
    set_v(10, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    set_v(11, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    set_v(12, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    set_v(13, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    // held request, D=2
    for (int i = 15; i <= 20; i++) set_v(i, 1'b1, 1'b1, 4'd2, (i >= 17), (i >= 16));
    set_v(21, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    set_v(22, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    // clamp low and high
    set_v(24, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    set_v(25, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    set_v(26, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    set_v(28, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    for (int i = 29; i <= 32; i++) set_v(i, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    set_v(33, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    // merge: D=5 then D=3 two edges later hit the same edge
    set_v(35, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    set_v(36, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    set_v(37, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
    set_v(38, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    set_v(39, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    set_v(40, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    // disabled request
    set_v(42, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);

    @(negedge clk);
    do_reset();
    en = 1'b1;

    for (int i = 0; i < 45; i++) begin
      chk("tab_rx_ack", int'(rx_ack), int'(tab[i].ack));
      chk("tab_busy", int'(busy), int'(tab[i].busy));
      chk("tab_clamp_err", int'(clamp_err), int'(tab[i].clamp));
      cycle(tab[i].req, tab[i].en, tab[i].cfg);
    end
    chk("tab_req_cnt", int'(req_cnt), 11);
    chk("tab_ack_cnt", int'(ack_cnt), 10);

    // reset in flight: request with D=4, reset between edges 2 and 3
    do_reset();
    cycle(1'b1, 1'b1, 4'd4);
    cycle(1'b0, 1'b1, 4'd0);
    cycle(1'b0, 1'b1, 4'd0);
    chk("pre_rst_busy", int'(busy), 1);
    #1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_ack", int'(rx_ack), 0);
      cycle(1'b0, 1'b1, 4'd0);
    end
    chk("post_rst_ack_cnt", int'(ack_cnt), 0);

    // first edge after release accepts; 20 held requests saturate the 4-bit counters
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 4'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'd0);
    chk("sat4_req_cnt", int'(s_req_cnt), 15);
    chk("sat4_ack_cnt", int'(s_ack_cnt), 15);
    chk("full_req_cnt", int'(req_cnt), 20);
    chk("full_ack_cnt", int'(ack_cnt), 20);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0),
            4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 4'd0);
    chk("drain_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
